// File: rtl/program_counter.sv
// program_counter: the architectural PC register.
// Loads the externally computed next-PC every rising edge and holds it until
// the next edge. Synchronous active-high reset forces RESET_VECTOR.
// Optional macro PC_ALIGN_EN: clears bits [1:0] of every loaded value and of
// the reset vector, so the PC is always word aligned.
module program_counter #(
  parameter int unsigned           WIDTH        = 32,
  parameter logic [WIDTH-1:0]      RESET_VECTOR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PC_in,
  output logic [WIDTH-1:0] PC_out
);

  // Maps a raw next-PC value to the value actually stored.
`ifdef PC_ALIGN_EN
  function automatic logic [WIDTH-1:0] f_align(input logic [WIDTH-1:0] v);
    f_align = {v[WIDTH-1:2], 2'b00};
  endfunction
`else
  function automatic logic [WIDTH-1:0] f_align(input logic [WIDTH-1:0] v);
    f_align = v;
  endfunction
`endif

  localparam logic [WIDTH-1:0] LP_RST_VEC = f_align(RESET_VECTOR);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;

  // Next-PC formatting; no arithmetic, any value is accepted as-is.
  always_comb begin
    w_pc_next = f_align(PC_in);
  end

  // PC register: reset has priority, otherwise load the next PC.
  always_ff @(posedge clk) begin
    if (reset) r_pc <= LP_RST_VEC;
    else       r_pc <= w_pc_next;
  end

  assign PC_out = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed timed sequence, a vector
// table, and randomized traffic checked against a behavioural model.
// Build with +define+PC_ALIGN_EN to exercise the aligned configuration.
module tb_program_counter;

  logic        clk;
  logic        reset;
  logic [31:0] PC_in;
  logic [31:0] PC_out;
  logic [31:0] PC_out_hi;

  int n_checks = 0;
  int n_pass   = 0;

  program_counter #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PC_in(PC_in), .PC_out(PC_out)
  );

  program_counter #(.WIDTH(32), .RESET_VECTOR(32'h8000_0000)) dut_hi (
    .clk(clk), .reset(reset), .PC_in(PC_in), .PC_out(PC_out_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the PC must read one edge after these inputs.
  function automatic logic [31:0] model_pc(input logic rst, input logic [31:0] pc,
                                           input logic [31:0] rv);
    logic [31:0] v;
    v = rst ? rv : pc;
`ifdef PC_ALIGN_EN
    v = v & 32'hFFFF_FFFC;
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        r_rst;
    logic [31:0] r_pc;

    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[3] = '{1'b1, 32'h1234_5678, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_1000, 32'h0000_1000};
    vecs[5] = '{1'b0, 32'hDEAD_BEE0, 32'hDEAD_BEE0};
`ifdef PC_ALIGN_EN
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[7] = '{1'b0, 32'h0000_0003, 32'h0000_0000};
`else
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[7] = '{1'b0, 32'h0000_0003, 32'h0000_0003};
`endif

    // Directed timed sequence
    reset = 1'b1; PC_in = 32'h0;
    #10;                                   // t=10
    check("reset_value", PC_out, 32'h0000_0000);
    check("reset_vector_hi", PC_out_hi, 32'h8000_0000);
    reset = 1'b0;
    #10;                                   // t=20
    check("post_reset_load0", PC_out, 32'h0);
    PC_in = 32'h4;
    #2;                                    // t=22
    check("hold_before_edge", PC_out, 32'h0);
    #8;                                    // t=30
    check("load_4", PC_out, 32'h4);
    #10;                                   // t=40
    check("hold_4", PC_out, 32'h4);
    PC_in = 32'h8;
    #10;                                   // t=50
    check("load_8", PC_out, 32'h8);
    #10;                                   // t=60
    PC_in = 32'hC;
    #10;                                   // t=70
    check("load_C", PC_out, 32'hC);
    reset = 1'b1;
    #2;                                    // t=72
    check("reset_waits_edge", PC_out, 32'hC);
    #8;                                    // t=80
    check("midrun_reset", PC_out, 32'h0);
    check("midrun_reset_hi", PC_out_hi, 32'h8000_0000);
    reset = 1'b0;
    #10;                                   // t=90
    check("reload_after_reset", PC_out, 32'hC);
    PC_in = 32'h14;
    #3;                                    // t=93
    check("midcycle_isolation", PC_out, 32'hC);
    PC_in = 32'h7;
    #7;                                    // t=100
`ifdef PC_ALIGN_EN
    check("align_7", PC_out, 32'h4);
`else
    check("align_7", PC_out, 32'h7);
`endif

    // Table-driven vectors: drive at negedge, check at following negedge
    for (int i = 0; i < 8; i++) begin
      reset = vecs[i].rst;
      PC_in = vecs[i].pc;
      #10;
      check($sformatf("vec%0d", i), PC_out, vecs[i].exp);
    end

    // Reset lasting several edges holds the vector
    reset = 1'b1; PC_in = 32'hABCD_0000;
    #20;
    check("long_reset", PC_out, 32'h0);
    check("long_reset_hi", PC_out_hi, 32'h8000_0000);

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      r_rst = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0:       r_pc = 32'h0;
        1:       r_pc = 32'hFFFF_FFFC;
        2:       r_pc = PC_out;
        default: r_pc = $urandom;
      endcase
      reset = r_rst;
      PC_in = r_pc;
      exp_lo = model_pc(r_rst, r_pc, 32'h0000_0000);
      exp_hi = model_pc(r_rst, r_pc, 32'h8000_0000);
      #10;
      check("rand_lo", PC_out, exp_lo);
      check("rand_hi", PC_out_hi, exp_hi);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
